tdc_hit_encoder: RTL and testbench

//  Readout end of the fine-time TDC path. Consumes the 32-sample phase word the

---
 rtl/tdc_hit_encoder.sv | 159 +++++++++++++++
 tb/tb_tdc_hit_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_encoder.sv
// Fine-time TDC readout: edge finder on 32-sample phase words,
// timestamping and a two-write event FIFO with drop accounting.
module tdc_hit_encoder #(
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [31:0]         din,
  output logic [COARSE_W+6:0] ev_data,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ovf,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int EW  = COARSE_W + 7;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DW1 = DROP_W + 1;

  logic [COARSE_W-1:0] r_coarse;
  logic                r_prev_bit;
  logic [31:0]         r_cap_din;
  logic                r_cap_en;
  logic                r_cap_prev;
  logic [COARSE_W-1:0] r_cap_coarse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coarse     <= '0;
      r_prev_bit   <= 1'b0;
      r_cap_din    <= '0;
      r_cap_en     <= 1'b0;
      r_cap_prev   <= 1'b0;
      r_cap_coarse <= '0;
    end else begin
      r_coarse     <= r_coarse + COARSE_W'(1);
      r_prev_bit   <= din[31];
      r_cap_din    <= din;
      r_cap_en     <= en;
      r_cap_prev   <= r_prev_bit;
      r_cap_coarse <= r_coarse;
    end
  end

  function automatic logic [4:0] lsb_idx(
    input logic [31:0] v
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) idx = 5'(i);
    return idx;
  endfunction

  logic [31:0]   w_prev_vec;
  logic [31:0]   w_rise;
  logic [31:0]   w_fall;
  logic          w_has_r;
  logic          w_has_f;
  logic [4:0]    w_idx_r;
  logic [4:0]    w_idx_f;
  logic [EW-1:0] w_ev_r;
  logic [EW-1:0] w_ev_f;
  logic [EW-1:0] w_first;
  logic [EW-1:0] w_second;
  logic [1:0]    w_need;

  // s[i-1] for every bit; bit 0 looks back into the previous word
  assign w_prev_vec = {r_cap_din[30:0], r_cap_prev};
  assign w_rise  = r_cap_din & ~w_prev_vec;
  assign w_fall  = ~r_cap_din & w_prev_vec;
  assign w_has_r = r_cap_en & (|w_rise);
  assign w_has_f = r_cap_en & (|w_fall);
  assign w_idx_r = lsb_idx(w_rise);
  assign w_idx_f = lsb_idx(w_fall);
  assign w_ev_r  = {|(w_rise & (w_rise - 32'd1)),
                    1'b1, r_cap_coarse, w_idx_r};
  assign w_ev_f  = {|(w_fall & (w_fall - 32'd1)),
                    1'b0, r_cap_coarse, w_idx_f};

  always_comb begin
    w_first  = '0;
    w_second = '0;
    w_need   = 2'd0;
    unique case (1'b1)
      (w_has_r && w_has_f): begin
        w_need = 2'd2;
        if (w_idx_r < w_idx_f) begin
          w_first  = w_ev_r;
          w_second = w_ev_f;
        end else begin
          w_first  = w_ev_f;
          w_second = w_ev_r;
        end
      end
      (w_has_r && !w_has_f): begin
        w_need  = 2'd1;
        w_first = w_ev_r;
      end
      (!w_has_r && w_has_f): begin
        w_need  = 2'd1;
        w_first = w_ev_f;
      end
      default: w_need = 2'd0;
    endcase
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic [CW-1:0] w_free;
  logic [1:0]    w_nwr;
  logic [1:0]    w_ndrop;
  logic [DW1-1:0] w_drop_sum;

  assign ev_valid = (r_count != '0);
  assign w_pop    = ev_valid & ev_ready;
  // a slot freed by this cycle's pop is reusable by this cycle's push
  assign w_free   = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
  assign w_nwr    = (CW'(w_need) <= w_free) ? w_need : w_free[1:0];
  assign w_ndrop  = w_need - w_nwr;
  assign w_drop_sum = {1'b0, drop_cnt} + DW1'(w_ndrop);
  assign ev_data  = ev_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (w_nwr != 2'd0)
      r_mem[r_wptr] <= w_first;
    if (w_nwr == 2'd2)
      r_mem[r_wptr + AW'(1)] <= w_second;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nwr);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + CW'(w_nwr) - CW'(w_pop);
      if (w_ndrop != 2'd0) begin
        ovf <= 1'b1;
        if (w_drop_sum[DROP_W])
          drop_cnt <= '1;
        else
          drop_cnt <= w_drop_sum[DROP_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Directed bench for tdc_hit_encoder: word-level model feeds a
// scoreboard queue, compared at every accepted FIFO head.
module tb_tdc_hit_encoder;

  localparam int EW = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [31:0]   din = '0;
  logic          ev_ready = 1'b0;
  logic [EW-1:0] ev_data;
  logic          ev_valid;
  logic          ovf;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  tdc_hit_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .ev_data  (ev_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] q[$];
  logic [15:0]   tb_cyc;
  logic          m_prev = 1'b0;
  int            m_drops = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 16'd1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [EW-1:0] e);
    if (q.size() >= 16) m_drops++;
    else q.push_back(e);
  endtask

  task automatic model_push(input logic [31:0] w,
                            input logic e);
    int ri, fi, rc, fc;
    logic sp;
    logic [EW-1:0] er, ef;
    ri = -1; fi = -1; rc = 0; fc = 0;
    for (int i = 0; i < 32; i++) begin
      sp = (i == 0) ? m_prev : w[i-1];
      if (w[i] && !sp) begin
        if (ri < 0) ri = i;
        rc++;
      end
      if (!w[i] && sp) begin
        if (fi < 0) fi = i;
        fc++;
      end
    end
    m_prev = w[31];
    er = {rc > 1, 1'b1, tb_cyc, 5'(ri)};
    ef = {fc > 1, 1'b0, tb_cyc, 5'(fi)};
    if (e) begin
      if (ri >= 0 && (fi < 0 || ri < fi)) begin
        push_ev(er);
        if (fi >= 0) push_ev(ef);
      end else if (fi >= 0) begin
        push_ev(ef);
        if (ri >= 0) push_ev(er);
      end
    end
  endtask

  task automatic step(input logic [31:0] w,
                      input logic e);
    @(posedge clk);
    #1;
    din = w;
    en  = e;
    model_push(w, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din = '0;
    en = 1'b0;
    q.delete();
    m_prev = 1'b0;
    m_drops = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (q.size() != 0 && k < limit) begin
      step('0, 1'b0);
      k++;
    end
    n_checks++;
    assert (q.size() == 0) else begin
      n_errors++;
      $error("FAIL drain got=%0d left exp=0", q.size());
    end
    repeat (3) step('0, 1'b0);
    chk("idle_valid", 32'(ev_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      n_checks++;
      assert (q.size() != 0) else begin
        n_errors++;
        $error("FAIL spurious got=%h exp=none", ev_data);
      end
      if (q.size() != 0)
        chk("event", 32'(ev_data), 32'(q.pop_front()));
    end
  end

  initial begin
    int guard;

    // reset state and basic two-edge word
    do_reset();
    ev_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_data", 32'(ev_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    step('0, 1'b0);
    step('0, 1'b0);
    step(32'h0000_FFE0, 1'b1);
    step('0, 1'b0);
    chk("lat_n1", 32'(ev_valid), 32'd0);
    step('0, 1'b0);
    chk("lat_n2", 32'(ev_valid), 32'd1);
    chk("t1_head", 32'(ev_data),
        32'({1'b0, 1'b1, 16'd3, 5'd5}));
    drain(20);

    // word boundary and multi-edge words
    step(32'hFFFF_0000, 1'b1);
    step(32'h0000_FFFF, 1'b1);
    drain(20);
    step(32'h0F0F_0F0F, 1'b1);
    drain(20);

    // overflow with stalled consumer
    do_reset();
    ev_ready = 1'b0;
    for (int k = 1; k <= 10; k++)
      step(32'hF << k, 1'b1);
    repeat (4) step('0, 1'b0);
    chk("ovf_drop", 32'(drop_cnt), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_model", 32'(drop_cnt), 32'(m_drops));
    chk("stall_head", 32'(ev_data),
        32'({1'b0, 1'b1, 16'd1, 5'd1}));
    step('0, 1'b0);
    chk("stall_hold", 32'(ev_data),
        32'({1'b0, 1'b1, 16'd1, 5'd1}));
    ev_ready = 1'b1;
    drain(40);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // coarse wrap and disabled capture
    guard = 0;
    while (tb_cyc != 16'hFFFE && guard < 70000) begin
      step('0, 1'b0);
      guard++;
    end
    step(32'h0000_00F0, 1'b1);
    step(32'h0000_0F00, 1'b1);
    step(32'h00FF_0000, 1'b0);
    drain(20);

    // reset while the FIFO holds five events
    ev_ready = 1'b0;
    step(32'h0000_FF00, 1'b1);
    step(32'h00FF_0000, 1'b1);
    step(32'h8000_0000, 1'b1);
    repeat (3) step('0, 1'b0);
    chk("pre_rst_valid", 32'(ev_valid), 32'd1);
    chk("pre_rst_q", 32'(q.size()), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ev_valid), 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    q.delete();
    m_prev = 1'b0;
    m_drops = 0;
    din = 32'hFFFF_FFFF;
    en = 1'b1;
    model_push(32'hFFFF_FFFF, 1'b1);
    chk("post_rst_q", 32'(q.size()), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
